fifo_sync_param: RTL and testbench

//  Parametrised single-clock FIFO, next generation of our FIFO block.

---
 rtl/fifo_sync_param.sv | 121 ++++++++++++
 tb/tb_fifo_sync_param.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty levels.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise data_out is registered.
module fifo_sync_param #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AF_LEVEL   = DEPTH - 1,
  parameter int unsigned AE_LEVEL   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         wr_en,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         wr_ack,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         full,
  output logic                         empty,
  output logic                         almostfull,
  output logic                         almostempty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  full_w, empty_w;
  logic                  wr_accept, rd_accept;

  // Flags come from the registered count only, never from this cycle's requests.
  assign full_w    = (count_q == CNT_W'(DEPTH));
  assign empty_w   = (count_q == '0);
  assign wr_accept = wr_en && !full_w;
  assign rd_accept = rd_en && !empty_w;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wr_ack_d    = wr_accept;
    overflow_d  = wr_en && full_w;
    underflow_d = rd_en && empty_w;
    if (wr_accept) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (rd_accept) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    unique case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

`ifdef FIFO_FWFT_EN
  assign data_out = empty_w ? '0 : mem_q[rd_ptr_q];
`else
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  always_comb begin
    data_out_d = data_out_q;
    if (rd_accept) begin
      data_out_d = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
`endif

  assign wr_ack      = wr_ack_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign full        = full_w;
  assign empty       = empty_w;
  assign almostfull  = (count_q >= CNT_W'(AF_LEVEL)) && !full_w;
  assign almostempty = !empty_w && (count_q <= CNT_W'(AE_LEVEL));
  assign count       = count_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: DEPTH=8 instance (a) and DEPTH=6 instance (b),
// each tracked by a queue scoreboard and a small occupancy/status model.
module tb_fifo_sync_param;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        wr_a = 1'b0, rd_a = 1'b0, wr_b = 1'b0, rd_b = 1'b0;
  logic [15:0] din_a = '0, din_b = '0;
  logic [15:0] dout_a, dout_b;
  logic        ack_a, ovf_a, unf_a, full_a, empty_a, af_a, ae_a;
  logic        ack_b, ovf_b, unf_b, full_b, empty_b, af_b, ae_b;
  logic [3:0]  cnt_a;
  logic [2:0]  cnt_b;

  fifo_sync_param #(.DATA_WIDTH(16), .DEPTH(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(din_a), .wr_en(wr_a), .rd_en(rd_a),
    .data_out(dout_a), .wr_ack(ack_a), .overflow(ovf_a), .underflow(unf_a),
    .full(full_a), .empty(empty_a), .almostfull(af_a), .almostempty(ae_a), .count(cnt_a)
  );

  fifo_sync_param #(.DATA_WIDTH(16), .DEPTH(6)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(din_b), .wr_en(wr_b), .rd_en(rd_b),
    .data_out(dout_b), .wr_ack(ack_b), .overflow(ovf_b), .underflow(unf_b),
    .full(full_b), .empty(empty_b), .almostfull(af_b), .almostempty(ae_b), .count(cnt_b)
  );

  int          errors = 0;
  int          checks = 0;
  int          stepno = 0;
  int          m_cnt  [2];
  logic [15:0] m_dout [2];
  logic        m_ack  [2];
  logic        m_ovf  [2];
  logic        m_unf  [2];
  logic [15:0] sba [$];
  logic [15:0] sbb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int u);
    int          depth;
    int          c;
    string       p;
    logic [15:0] exp_d;
    logic [15:0] o_d;
    logic [31:0] o_cnt;
    logic        o_ack, o_ovf, o_unf, o_full, o_empty, o_af, o_ae;
    depth = (u == 0) ? 8 : 6;
    c     = m_cnt[u];
    p     = $sformatf("s%0d.%s.", stepno, (u == 0) ? "a" : "b");
`ifdef FIFO_FWFT_EN
    if (u == 0) exp_d = (sba.size() > 0) ? sba[0] : 16'h0;
    else        exp_d = (sbb.size() > 0) ? sbb[0] : 16'h0;
`else
    exp_d = m_dout[u];
`endif
    if (u == 0) begin
      o_cnt = 32'(cnt_a); o_d = dout_a; o_ack = ack_a; o_ovf = ovf_a; o_unf = unf_a;
      o_full = full_a; o_empty = empty_a; o_af = af_a; o_ae = ae_a;
    end else begin
      o_cnt = 32'(cnt_b); o_d = dout_b; o_ack = ack_b; o_ovf = ovf_b; o_unf = unf_b;
      o_full = full_b; o_empty = empty_b; o_af = af_b; o_ae = ae_b;
    end
    chk({p, "count"},       o_cnt,       32'(c));
    chk({p, "full"},        32'(o_full),  32'(c == depth));
    chk({p, "empty"},       32'(o_empty), 32'(c == 0));
    chk({p, "almostfull"},  32'(o_af),    32'(c >= depth - 1 && c < depth));
    chk({p, "almostempty"}, 32'(o_ae),    32'(c > 0 && c <= 1));
    chk({p, "wr_ack"},      32'(o_ack),   32'(m_ack[u]));
    chk({p, "overflow"},    32'(o_ovf),   32'(m_ovf[u]));
    chk({p, "underflow"},   32'(o_unf),   32'(m_unf[u]));
    chk({p, "data_out"},    32'(o_d),     32'(exp_d));
  endtask

  // One clock cycle on instance u; the model is advanced, then all outputs compared.
  task automatic step(input int u, input logic wr, input logic rd, input logic [15:0] d);
    int          depth;
    logic        wacc, racc;
    logic [15:0] popped;
    depth = (u == 0) ? 8 : 6;
    stepno++;
    if (u == 0) begin wr_a = wr; rd_a = rd; din_a = d; end
    else        begin wr_b = wr; rd_b = rd; din_b = d; end
    @(posedge clk);
    #1;
    wacc     = wr && (m_cnt[u] != depth);
    racc     = rd && (m_cnt[u] != 0);
    m_ack[u] = wacc;
    m_ovf[u] = wr && (m_cnt[u] == depth);
    m_unf[u] = rd && (m_cnt[u] == 0);
    if (racc) begin
      popped    = (u == 0) ? sba.pop_front() : sbb.pop_front();
      m_dout[u] = popped;
    end
    if (wacc) begin
      if (u == 0) sba.push_back(d);
      else        sbb.push_back(d);
    end
    m_cnt[u] = m_cnt[u] + int'(wacc) - int'(racc);
    check_dut(u);
    wr_a = 1'b0; rd_a = 1'b0; wr_b = 1'b0; rd_b = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      m_cnt[u] = 0; m_dout[u] = '0; m_ack[u] = 1'b0; m_ovf[u] = 1'b0; m_unf[u] = 1'b0;
    end
    sba.delete();
    sbb.delete();
    stepno++;
    check_dut(0);
    check_dut(1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();
    step(0, 1'b0, 1'b0, 16'h0);
    step(1, 1'b0, 1'b0, 16'h0);

    // Mid-stream reset with five words stored.
    for (int i = 0; i < 5; i++) step(0, 1'b1, 1'b0, 16'h5500 + 16'(i));
    #2;
    do_reset();

    // Fill to full, then one rejected write.
    for (int i = 0; i < 8; i++) step(0, 1'b1, 1'b0, 16'hA000 + 16'(i));
    step(0, 1'b1, 1'b0, 16'hDEAD);
    step(0, 1'b0, 1'b0, 16'h0);

    // Drain, then one rejected read; data_out must hold the last word.
    for (int i = 0; i < 8; i++) step(0, 1'b0, 1'b1, 16'h0);
    step(0, 1'b0, 1'b1, 16'h0);
    step(0, 1'b0, 1'b0, 16'h0);

    // Simultaneous requests at empty, full and mid-level.
    step(0, 1'b1, 1'b1, 16'hB000);
    for (int i = 1; i < 8; i++) step(0, 1'b1, 1'b0, 16'hB000 + 16'(i));
    step(0, 1'b1, 1'b1, 16'hBEEF);
    for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b1, 16'h0);
    step(0, 1'b1, 1'b1, 16'hC004);
    for (int i = 0; i < 4; i++) step(0, 1'b0, 1'b1, 16'h0);

    // Non-power-of-two depth: interleaved traffic forcing full and pointer wrap.
    for (int i = 0; i < 20; i++) begin
      if (i < 12) step(1, 1'b1, (i % 3) == 2, 16'h6000 + 16'(i));
      else        step(1, (i % 2) == 0, 1'b1, 16'h6000 + 16'(i));
      chk($sformatf("s%0d.b.count_le_depth", stepno), 32'(cnt_b <= 3'd6), 32'd1);
    end
    while (sbb.size() > 0) step(1, 1'b0, 1'b1, 16'h0);
    step(1, 1'b0, 1'b1, 16'h0);

    // Single word through an empty FIFO: visible next cycle in FWFT, popped by rd_en.
    step(0, 1'b1, 1'b0, 16'h1234);
    step(0, 1'b0, 1'b0, 16'h0);
    step(0, 1'b0, 1'b1, 16'h0);
    step(0, 1'b0, 1'b0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
